// File: rtl/cpu_pkg.sv
// Shared CPU I/O definitions: bus width, bus-source select codes and the
// read-edge FSM state type used by the InPort (and its OutPort companion).
package cpu_pkg;

    localparam int DATA_W = 32;

    // Select codes for the DataPath bus multiplexer sources.
    typedef enum logic [2:0] {
        BUS_SRC_NONE   = 3'd0,
        BUS_SRC_REG    = 3'd1,
        BUS_SRC_PC     = 3'd2,
        BUS_SRC_MDR    = 3'd3,
        BUS_SRC_INPORT = 3'd4,
        BUS_SRC_CONST  = 3'd5
    } bus_src_t;

    // IDLE: waiting for a rising InPortout; HOLD: assertion in progress.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } port_state_t;

endpackage

// File: rtl/inport_buffer_if.sv
// Producer-side valid/ready handshake into the InPort buffer.
interface inport_buffer_if #(
    parameter int DATA_W = cpu_pkg::DATA_W
);
    logic [DATA_W-1:0] ext_data;
    logic              ext_valid;
    logic              ext_ready;

    // External producer drives data/valid and observes ready.
    modport master (
        output ext_data,
        output ext_valid,
        input  ext_ready
    );

    // The buffer consumes data/valid and reports ready.
    modport slave (
        input  ext_data,
        input  ext_valid,
        output ext_ready
    );
endinterface

// File: rtl/inport_fifo.sv
// DEPTH x DATA_W FIFO with power-of-two wrapping pointers and an AW+1 bit
// occupancy count. Push is refused when full, pop is refused when empty.
module inport_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Qualify requests against the current occupancy; full/empty come from count.
    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
        rd_data = mem[rd_ptr];
    end

    // Storage is written without reset; contents are only visible once counted.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inport_buffer.sv
// CPU InPort: buffers producer words and presents one word on the bus per
// rising edge of InPortout. The word appears in the same cycle as the edge
// and is then held until the next read.
module inport_buffer
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clock,
    input  logic              clear,
    inport_buffer_if.slave    prod,
    input  logic              InPortout,
    output logic [DATA_W-1:0] BusMuxIn_InPort,
    output logic              in_avail,
    output logic [AW:0]       in_count,
    output logic              underrun,
    input  logic              underrun_clr
);

    port_state_t       state;
    logic              rd_prev;
    logic              rd_start;
    logic [DATA_W-1:0] hold_reg;
    logic [DATA_W-1:0] fifo_rd_data;
    logic [DATA_W-1:0] shown_word;
    logic              fifo_full;
    logic              fifo_empty;

    inport_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_fifo (
        .clock   (clock),
        .clear   (clear),
        .push    (prod.ext_valid),
        .wr_data (prod.ext_data),
        .pop     (rd_start),
        .rd_data (fifo_rd_data),
        .count   (in_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Read edge detect and zero-latency bus view: an empty read shows zero.
    always_comb begin
        rd_start        = InPortout & ~rd_prev;
        shown_word      = fifo_empty ? '0 : fifo_rd_data;
        BusMuxIn_InPort = rd_start ? shown_word : hold_reg;
        prod.ext_ready  = ~fifo_full;
        in_avail        = ~fifo_empty;
    end

    // Read-edge FSM; rd_prev resets low so a held InPortout after clear is a new read.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            rd_prev <= 1'b0;
        end else begin
            rd_prev <= InPortout;
            case (state)
                IDLE:    if (rd_start)   state <= HOLD;
                HOLD:    if (!InPortout) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the word shown on the read edge so it stays on the bus afterwards.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            hold_reg <= '0;
        end else if (rd_start) begin
            hold_reg <= shown_word;
        end
    end

    // Sticky underrun; a new empty read takes priority over the clear request.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            underrun <= 1'b0;
        end else if (rd_start && fifo_empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule
